gather_multi_vc_input_controller: RTL and testbench
===================================================

// Module: gather_multi_vc_input_controller
// PURPOSE
//  Input-port controller for gather/FC router ports with NIVC input VCs (one FIFO each) sharing one crossbar input.
//  Per input VC: requests an output VC for each head flit, holds it until tail, optionally gates head requests on downstream credit.
//  Arbitrates round-robin among VCs holding an output VC, drives crossbar VC select, counts credit-starvation cycles.
//  Sits between input buffers/route_calculator and vc_allocator/crossbar.
// PARAMETERS
//  X_POS      0   router x coordinate (debug/ID only)
//  Y_POS      0   router y coordinate (debug/ID only)
//  NIVC       2   input VCs on this port, >=1
//  CN         `CN output VCs per output port
//  IS_FC      0   1: FC start port, credit gating on head requests
//  FC_PKT_LEN 16  FC packet length in flits
//  CRD_MARGIN 2   head request allowed when credit_cnt >= FC_PKT_LEN-CRD_MARGIN
//  STALL_W    16  width of starvation counter
// PORTS
//  clk              in  1           clock
//  rstn             in  1           asynchronous active-low reset
//  fifo_empty       in  NIVC        per-IVC input FIFO empty
//  flit_type        in  NIVC*2      per-IVC FIFO head flit type (`HEAD/`BODY/`TAIL)
//  candidate_out_vc in  NIVC*CN     per-IVC candidate VCs from route_calculator
//  req_vc           out NIVC*CN     per-IVC request to vc_allocator
//  vc_grant         in  NIVC        allocator grant, at most one bit/cycle
//  sel_out_vc       in  CN          granted output VC, one-hot, valid with vc_grant
//  sel_ivc          out NIVC        IVC chosen this cycle, one-hot or 0
//  sel_xb_vc        out CN          output VC of chosen IVC, to crossbar
//  flit_fire        in  1           flit of sel_ivc leaves this cycle
//  credit_cnt       in  32          downstream credit count
//  crd_starved      out 1           FC gating currently blocks a pending head
//  stall_cnt        out STALL_W     saturating count of crd_starved cycles
// BEHAVIOUR
//  Reset (rstn low, async): all IVC FSMs IDLE, held VCs 0, rr pointer 0, stall_cnt 0; all outputs 0.
//  Per-IVC FSM: IDLE -> ACTIVE on vc_grant[i] (latch sel_out_vc); ACTIVE -> IDLE on flit_fire & sel_ivc[i] & flit_type[i]==`TAIL.
//  req_vc[i] = candidate_out_vc[i] when IDLE & ~fifo_empty[i] & flit_type[i]==`HEAD & crd_ok, else 0; combinational.
//  crd_ok = IS_FC ? (credit_cnt >= FC_PKT_LEN-CRD_MARGIN) : 1; compare unsigned 32-bit, threshold clamped at 0.
//  Grant cycle bypass: IVC with vc_grant[i] in IDLE is eligible same cycle and uses sel_out_vc.
//  Eligible[i] = (ACTIVE | bypass) & ~fifo_empty[i]. Round-robin over eligible, start at pointer; 0 eligible -> sel_ivc=0, sel_xb_vc=0.
//  Pointer moves to winner+1 (mod NIVC) only on flit_fire; no fire -> same winner next cycle (no starvation hop mid-hold).
//  sel_xb_vc = held VC of winner (ACTIVE) or sel_out_vc (bypass).
//  Tail fire with vc_grant same IVC impossible (grant only in IDLE); grant to other IVC same cycle as tail fire: both update.
//  flit_fire with sel_ivc==0: ignored. Non-HEAD flit at head of IDLE IVC: no request, no state change.
//  crd_starved = IS_FC & ~crd_ok & any IVC IDLE with ~fifo_empty and `HEAD; stall_cnt += crd_starved, saturates at all-ones.
//  Reset mid-packet: held VC dropped, FSM IDLE; upstream re-sync is system responsibility.
//  IS_FC=0: crd_starved and stall_cnt tied 0.
// STRUCTURE
//  gather_pkg: ivc_state_e {IDLE, ACTIVE}, flit type constants mirrored from params.svh, clamp helper for threshold.
//  Sub-module rr_arbiter #(N) (req, advance, grant one-hot, pointer state); one instance, N=NIVC.
//  Per-IVC FSM + held-VC register in a generate loop.
// TESTING
//  NIVC=2, IVC0 HEAD, cand=5'b00010, grant with sel_out_vc=00010 -> same cycle sel_ivc=01, sel_xb_vc=00010; then ACTIVE.
//  IVC0 4-flit packet, flit_fire every cycle -> TAIL fire returns IDLE, next cycle sel_ivc=0, req_vc re-asserts if new HEAD.
//  Both IVCs ACTIVE, non-empty, fire every cycle -> sel_ivc alternates 01,10,01; fire low 3 cycles -> winner held.
//  IS_FC=1, credit_cnt=13, HEAD pending -> req_vc=0, crd_starved=1, stall_cnt +1/cycle; credit_cnt=14 -> request asserts.
//  STALL_W=4, 20 starved cycles -> stall_cnt stays 4'hF.
//  rstn low mid-packet on ACTIVE IVC -> all outputs 0 immediately, IDLE after release, held VC 0.

Source files
------------

// File: rtl/gather_multi_vc_input_controller_pkg.sv
// Shared types and constants for the gather/FC input-port controller.
// Flit type encoding mirrors the router-wide params.svh values.
package gather_multi_vc_input_controller_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } ivc_state_e;

  localparam logic [1:0] FLIT_BODY = 2'b00;
  localparam logic [1:0] FLIT_HEAD = 2'b01;
  localparam logic [1:0] FLIT_TAIL = 2'b10;

  // Credit threshold for FC head requests; never wraps below zero.
  function automatic logic [31:0] crd_threshold(input int pkt_len, input int margin);
    int diff;
    diff = pkt_len - margin;
    return (diff > 0) ? 32'(diff) : 32'd0;
  endfunction

endpackage

// File: rtl/gather_multi_vc_input_controller_rr_arbiter.sv
// Round-robin arbiter: search starts at the pointer; the pointer moves past
// the winner only when the granted requester actually advances.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] win_idx;
  logic          found;
  int            idx;

  always_comb begin
    grant   = '0;
    win_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int off = 0; off < N; off++) begin
      idx = int'(ptr_q) + off;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        win_idx    = PW'(idx);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance && found) begin
      ptr_d = (win_idx == PW'(N - 1)) ? '0 : PW'(win_idx + 1'b1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/gather_multi_vc_input_controller.sv
// Input-port controller for gather/FC ports: per-IVC output-VC hold FSM,
// FC credit gating of head requests, round-robin crossbar VC select.
//
// state  | meaning
// IDLE   | no output VC held; a HEAD at the FIFO front requests one
// ACTIVE | output VC held for the current packet until its TAIL leaves
module gather_multi_vc_input_controller
  import gather_multi_vc_input_controller_pkg::*;
#(
  parameter int X_POS      = 0,
  parameter int Y_POS      = 0,
  parameter int NIVC       = 2,
  parameter int CN         = 5,
  parameter int IS_FC      = 0,
  parameter int FC_PKT_LEN = 16,
  parameter int CRD_MARGIN = 2,
  parameter int STALL_W    = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NIVC-1:0]      fifo_empty,
  input  logic [NIVC*2-1:0]    flit_type,
  input  logic [NIVC*CN-1:0]   candidate_out_vc,
  output logic [NIVC*CN-1:0]   req_vc,
  input  logic [NIVC-1:0]      vc_grant,
  input  logic [CN-1:0]        sel_out_vc,
  output logic [NIVC-1:0]      sel_ivc,
  output logic [CN-1:0]        sel_xb_vc,
  input  logic                 flit_fire,
  input  logic [31:0]          credit_cnt,
  output logic                 crd_starved,
  output logic [STALL_W-1:0]   stall_cnt
);

  localparam logic [31:0] CRD_THR = crd_threshold(FC_PKT_LEN, CRD_MARGIN);

  logic            crd_ok;
  logic [NIVC-1:0] pend_head;
  logic [NIVC-1:0] eligible;
  logic [NIVC-1:0] arb_grant;
  logic [CN-1:0]   ivc_vc [NIVC];

  assign crd_ok = (IS_FC == 0) || (credit_cnt >= CRD_THR);

  for (genvar i = 0; i < NIVC; i++) begin : g_ivc
    ivc_state_e    state_q, state_d;
    logic [CN-1:0] held_q, held_d;
    logic          is_idle;

    assign is_idle      = (state_q == IDLE);
    assign pend_head[i] = is_idle && !fifo_empty[i] && (flit_type[2*i +: 2] == FLIT_HEAD);
    // Grant-cycle bypass lets the head flit leave in the same cycle it is granted.
    assign eligible[i]  = rstn && !fifo_empty[i] && (!is_idle || vc_grant[i]);
    assign ivc_vc[i]    = is_idle ? sel_out_vc : held_q;
    assign req_vc[CN*i +: CN] = (rstn && pend_head[i] && crd_ok) ?
                                candidate_out_vc[CN*i +: CN] : '0;

    always_comb begin
      state_d = state_q;
      held_d  = held_q;
      case (state_q)
        IDLE: begin
          if (vc_grant[i]) begin
            state_d = ACTIVE;
            held_d  = sel_out_vc;
          end
        end
        ACTIVE: begin
          if (flit_fire && sel_ivc[i] && (flit_type[2*i +: 2] == FLIT_TAIL)) begin
            state_d = IDLE;
            held_d  = '0;
          end
        end
        default: begin
          state_d = IDLE;
          held_d  = '0;
        end
      endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        state_q <= IDLE;
        held_q  <= '0;
      end else begin
        state_q <= state_d;
        held_q  <= held_d;
      end
    end
  end

  rr_arbiter #(.N(NIVC)) u_rr (
    .clk     (clk),
    .rstn    (rstn),
    .req     (eligible),
    .advance (flit_fire),
    .grant   (arb_grant)
  );

  assign sel_ivc = arb_grant & {NIVC{rstn}};

  always_comb begin
    sel_xb_vc = '0;
    for (int i = 0; i < NIVC; i++) begin
      if (sel_ivc[i]) sel_xb_vc = sel_xb_vc | ivc_vc[i];
    end
  end

  if (IS_FC != 0) begin : g_fc
    logic [STALL_W-1:0] stall_q, stall_d;

    assign crd_starved = rstn && !crd_ok && (|pend_head);

    always_comb begin
      stall_d = stall_q;
      if (crd_starved && (stall_q != '1)) stall_d = stall_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) stall_q <= '0;
      else       stall_q <= stall_d;
    end

    assign stall_cnt = stall_q;
  end else begin : g_no_fc
    assign crd_starved = 1'b0;
    assign stall_cnt   = '0;
  end

endmodule

// File: tb/tb_gather_multi_vc_input_controller.sv
// Directed bench: a non-FC instance for VC hold/arbitration and an FC
// instance (STALL_W=4) for credit gating and starvation counting.
module tb_gather_multi_vc_input_controller;
  import gather_multi_vc_input_controller_pkg::*;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [1:0]  a_fe, b_fe;
  logic [3:0]  a_ft, b_ft;
  logic [9:0]  a_cand, b_cand;
  logic [9:0]  a_req, b_req;
  logic [1:0]  a_gr, b_gr;
  logic [4:0]  a_so, b_so;
  logic [1:0]  a_sel, b_sel;
  logic [4:0]  a_xb, b_xb;
  logic        a_ff, b_ff;
  logic [31:0] a_crd, b_crd;
  logic        a_starved, b_starved;
  logic [15:0] a_stall;
  logic [3:0]  b_stall;

  gather_multi_vc_input_controller #(
    .NIVC(2), .CN(5), .IS_FC(0), .STALL_W(16)
  ) dut_a (
    .clk(clk), .rstn(rstn), .fifo_empty(a_fe), .flit_type(a_ft),
    .candidate_out_vc(a_cand), .req_vc(a_req), .vc_grant(a_gr),
    .sel_out_vc(a_so), .sel_ivc(a_sel), .sel_xb_vc(a_xb),
    .flit_fire(a_ff), .credit_cnt(a_crd), .crd_starved(a_starved),
    .stall_cnt(a_stall)
  );

  gather_multi_vc_input_controller #(
    .NIVC(2), .CN(5), .IS_FC(1), .FC_PKT_LEN(16), .CRD_MARGIN(2), .STALL_W(4)
  ) dut_b (
    .clk(clk), .rstn(rstn), .fifo_empty(b_fe), .flit_type(b_ft),
    .candidate_out_vc(b_cand), .req_vc(b_req), .vc_grant(b_gr),
    .sel_out_vc(b_so), .sel_ivc(b_sel), .sel_xb_vc(b_xb),
    .flit_fire(b_ff), .credit_cnt(b_crd), .crd_starved(b_starved),
    .stall_cnt(b_stall)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic a_drive(input logic [1:0] fe, input logic [3:0] ft, input logic [9:0] cand,
                         input logic [1:0] gr, input logic [4:0] so, input logic ff);
    a_fe = fe; a_ft = ft; a_cand = cand; a_gr = gr; a_so = so; a_ff = ff;
  endtask

  task automatic a_exp(input string tag, input logic [9:0] req, input logic [1:0] sel,
                       input logic [4:0] xb);
    #1;
    chk({tag, ".req"}, 32'(a_req), 32'(req));
    chk({tag, ".sel"}, 32'(a_sel), 32'(sel));
    chk({tag, ".xb"},  32'(a_xb),  32'(xb));
    @(negedge clk);
  endtask

  initial begin
    rstn = 1'b0;
    b_fe = 2'b11; b_ft = {FLIT_BODY, FLIT_HEAD}; b_cand = 10'h001;
    b_gr = 2'b00; b_so = 5'b0; b_ff = 1'b0; b_crd = 32'd0;
    a_crd = 32'd0;

    // Outputs forced low during reset even with a head and a grant present.
    a_drive(2'b10, {FLIT_BODY, FLIT_HEAD}, 10'h002, 2'b01, 5'b00010, 1'b1);
    #1;
    chk("rst.b_stall", 32'(b_stall), 32'd0);
    chk("rst.b_starved", 32'(b_starved), 32'd0);
    chk("rst.a_stall", 32'(a_stall), 32'd0);
    a_exp("rst", 10'h000, 2'b00, 5'b00000);
    rstn = 1'b1;

    a_drive(2'b10, {FLIT_BODY, FLIT_HEAD}, 10'h002, 2'b00, 5'b0, 1'b0);
    a_exp("s1_req", 10'h002, 2'b00, 5'b00000);
    a_drive(2'b10, {FLIT_BODY, FLIT_HEAD}, 10'h002, 2'b01, 5'b00010, 1'b0);
    a_exp("s2_bypass", 10'h002, 2'b01, 5'b00010);
    a_drive(2'b10, {FLIT_BODY, FLIT_HEAD}, 10'h002, 2'b00, 5'b0, 1'b1);
    a_exp("s3_head", 10'h000, 2'b01, 5'b00010);
    a_drive(2'b10, {FLIT_BODY, FLIT_BODY}, 10'h002, 2'b00, 5'b0, 1'b1);
    a_exp("s4_body", 10'h000, 2'b01, 5'b00010);
    a_exp("s5_body", 10'h000, 2'b01, 5'b00010);
    a_drive(2'b10, {FLIT_BODY, FLIT_TAIL}, 10'h002, 2'b00, 5'b0, 1'b1);
    a_exp("s6_tail", 10'h000, 2'b01, 5'b00010);
    a_drive(2'b10, {FLIT_BODY, FLIT_BODY}, 10'h002, 2'b00, 5'b0, 1'b0);
    a_exp("s7_idle_body", 10'h000, 2'b00, 5'b00000);
    a_drive(2'b10, {FLIT_BODY, FLIT_HEAD}, 10'h004, 2'b00, 5'b0, 1'b0);
    a_exp("s8_rereq", 10'h004, 2'b00, 5'b00000);
    a_drive(2'b10, {FLIT_BODY, FLIT_HEAD}, 10'h004, 2'b01, 5'b00100, 1'b0);
    a_exp("s9_grant0", 10'h004, 2'b01, 5'b00100);

    // Pointer now 1: IVC1 bypass wins over active IVC0.
    a_drive(2'b00, {FLIT_HEAD, FLIT_BODY}, 10'h104, 2'b10, 5'b01000, 1'b0);
    a_exp("s10_grant1", 10'h100, 2'b10, 5'b01000);
    a_drive(2'b00, {FLIT_BODY, FLIT_BODY}, 10'h104, 2'b00, 5'b0, 1'b1);
    a_exp("s11_rr", 10'h000, 2'b10, 5'b01000);
    a_exp("s12_rr", 10'h000, 2'b01, 5'b00100);
    a_exp("s13_rr", 10'h000, 2'b10, 5'b01000);
    a_drive(2'b00, {FLIT_BODY, FLIT_BODY}, 10'h104, 2'b00, 5'b0, 1'b0);
    a_exp("s14_hold", 10'h000, 2'b01, 5'b00100);
    a_exp("s15_hold", 10'h000, 2'b01, 5'b00100);
    a_exp("s16_hold", 10'h000, 2'b01, 5'b00100);
    a_drive(2'b00, {FLIT_BODY, FLIT_BODY}, 10'h104, 2'b00, 5'b0, 1'b1);
    a_exp("s17_fire", 10'h000, 2'b01, 5'b00100);
    a_drive(2'b00, {FLIT_BODY, FLIT_BODY}, 10'h104, 2'b00, 5'b0, 1'b0);
    a_exp("s18_next", 10'h000, 2'b10, 5'b01000);
    a_drive(2'b11, {FLIT_BODY, FLIT_BODY}, 10'h104, 2'b00, 5'b0, 1'b1);
    a_exp("s19_nofire", 10'h000, 2'b00, 5'b00000);
    a_drive(2'b00, {FLIT_BODY, FLIT_BODY}, 10'h104, 2'b00, 5'b0, 1'b0);
    a_exp("s20_ptrkept", 10'h000, 2'b10, 5'b01000);
    a_drive(2'b00, {FLIT_TAIL, FLIT_BODY}, 10'h104, 2'b00, 5'b0, 1'b1);
    a_exp("s21_tail1", 10'h000, 2'b10, 5'b01000);
    a_drive(2'b00, {FLIT_HEAD, FLIT_BODY}, 10'h204, 2'b00, 5'b0, 1'b0);
    a_exp("s22_ivc1idle", 10'h200, 2'b01, 5'b00100);

    // Reset while IVC0 holds a VC.
    rstn = 1'b0;
    a_drive(2'b00, {FLIT_HEAD, FLIT_BODY}, 10'h204, 2'b10, 5'b10000, 1'b0);
    a_exp("s23_rst", 10'h000, 2'b00, 5'b00000);
    rstn = 1'b1;
    a_drive(2'b00, {FLIT_BODY, FLIT_BODY}, 10'h204, 2'b00, 5'b0, 1'b0);
    a_exp("s24_postrst", 10'h000, 2'b00, 5'b00000);
    a_drive(2'b00, {FLIT_HEAD, FLIT_HEAD}, 10'h204, 2'b00, 5'b0, 1'b0);
    a_exp("s25_bothidle", 10'h204, 2'b00, 5'b00000);
    a_drive(2'b00, {FLIT_HEAD, FLIT_HEAD}, 10'h204, 2'b01, 5'b10000, 1'b0);
    a_exp("s26_regrant", 10'h204, 2'b01, 5'b10000);
    a_drive(2'b10, {FLIT_HEAD, FLIT_BODY}, 10'h204, 2'b00, 5'b0, 1'b0);
    a_exp("s27_newheld", 10'h000, 2'b01, 5'b10000);

    // FC gating on instance B: threshold 16-2 = 14.
    a_drive(2'b11, {FLIT_BODY, FLIT_BODY}, 10'h000, 2'b00, 5'b0, 1'b0);
    b_fe = 2'b10; b_ft = {FLIT_BODY, FLIT_HEAD}; b_crd = 32'd13;
    #1;
    chk("fc13.req", 32'(b_req), 32'd0);
    chk("fc13.starved", 32'(b_starved), 32'd1);
    chk("fc13.stall0", 32'(b_stall), 32'd0);
    chk("fc13.sel", 32'(b_sel), 32'd0);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("stall_k%0d", k), 32'(b_stall), (k < 15) ? 32'(k) : 32'd15);
    end
    @(negedge clk);
    b_crd = 32'd14;
    #1;
    chk("fc14.req", 32'(b_req), 32'h001);
    chk("fc14.starved", 32'(b_starved), 32'd0);
    @(negedge clk);
    #1;
    chk("fc14.stall", 32'(b_stall), 32'hF);
    b_crd = 32'hFFFF_FFFF;
    #1;
    chk("fcmax.req", 32'(b_req), 32'h001);
    @(negedge clk);
    b_crd = 32'd0; b_fe = 2'b11;
    #1;
    chk("fcempty.starved", 32'(b_starved), 32'd0);
    chk("fcempty.req", 32'(b_req), 32'd0);
    @(negedge clk);
    b_fe = 2'b10; b_ft = {FLIT_BODY, FLIT_BODY};
    #1;
    chk("fcbody.starved", 32'(b_starved), 32'd0);
    chk("fcbody.req", 32'(b_req), 32'd0);
    chk("nofc.starved", 32'(a_starved), 32'd0);
    chk("nofc.stall", 32'(a_stall), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
